// File: rtl/glyph_scroll_buffer_pkg.sv
// Shared definitions for the scrolling glyph buffer: matrix size, FSM states
// and the glyph strip ROM (four 16x16 glyphs, glyph-major, bit 15 = top row).
package glyph_pkg;

    localparam int MATRIX_DIM = 16;
    localparam int ROM_COLS   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_e;

    localparam logic [15:0] GLYPH_ROM [ROM_COLS] = '{
        16'h1040, 16'h1040, 16'h1FC0, 16'h13FF, 16'h1040, 16'h0000, 16'h0FF0, 16'h1008,
        16'h1008, 16'h0FF0, 16'h0000, 16'h1FF8, 16'h0080, 16'h0080, 16'h1FF8, 16'h0000,
        16'h0200, 16'h0600, 16'h0E00, 16'h1E00, 16'h3E00, 16'h7E00, 16'hFE00, 16'hFFFE,
        16'hFE00, 16'h7E00, 16'h3E00, 16'h1E00, 16'h0E00, 16'h0600, 16'h0200, 16'h0000,
        16'h3FF0, 16'h2010, 16'h2010, 16'h2010, 16'h3FF0, 16'h0000, 16'h1FE0, 16'h2010,
        16'h2010, 16'h1FE0, 16'h0000, 16'h3C3C, 16'h4242, 16'h4242, 16'h3C3C, 16'h0000,
        16'h0000, 16'h7FE0, 16'h4020, 16'h4020, 16'h7FE0, 16'h0000, 16'h0810, 16'h1818,
        16'h3C3C, 16'h7E7E, 16'h3C3C, 16'h1818, 16'h0810, 16'h0000, 16'h0001, 16'h8001
    };

endpackage

// File: rtl/glyph_scroll_buffer_rom.sv
// Combinational glyph strip lookup: strip column address -> 16-bit row pattern.
module glyph_rom
    import glyph_pkg::*;
#(
    parameter int POS_W = 6
) (
    input  logic [POS_W-1:0] addr_i,
    output logic [15:0]      data_o
);

    assign data_o = GLYPH_ROM[addr_i];

endmodule

// File: rtl/glyph_scroll_buffer.sv
// Double-buffered 16-column frame feeding the LED column scanner; the back bank
// is refilled from the glyph strip per scroll step and swapped on frame_sync.
module glyph_scroll_buffer
    import glyph_pkg::*;
#(
    parameter int NUM_GLYPHS  = 4,
    parameter int STEP_FRAMES = 8,
    parameter int POS_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       col_addr,
    input  logic             frame_sync,
    output logic [15:0]      row_data,
    output logic [POS_W-1:0] scroll_pos,
    output logic             busy
);

    localparam int STRIP_COLS = NUM_GLYPHS * MATRIX_DIM;
    localparam int FC_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(STEP_FRAMES - 1);
    localparam logic [POS_W-1:0] POS_MASK = POS_W'(STRIP_COLS - 1);

    state_e             state_q, state_d;
    logic [3:0]         fill_idx_q, fill_idx_d;
    logic [POS_W-1:0]   pos_lat_q, pos_lat_d;
    logic [POS_W-1:0]   scroll_pos_q, scroll_pos_d;
    logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic               step_pending_q, step_pending_d;
    logic               bank_sel_q, bank_sel_d;
    logic [15:0]        row_data_q;
    logic [15:0]        bank_q [2][MATRIX_DIM];

    logic               step, fill_we, fill_start, swap;
    logic [POS_W-1:0]   rom_addr;
    logic [15:0]        rom_data;

    glyph_rom #(.POS_W(POS_W)) u_rom (
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Reset lands directly in FILL so the offset-0 window loads without a step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (step_pending_q)        state_d = FILL;
            FILL:    if (fill_idx_q == 4'd15)   state_d = READY;
            READY:   if (frame_sync)            state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    always_comb begin
        fill_we    = 1'b0;
        fill_start = 1'b0;
        swap       = 1'b0;
        busy       = step_pending_q;
        case (state_q)
            IDLE:    fill_start = step_pending_q;
            FILL:    begin fill_we = 1'b1; busy = 1'b1; end
            READY:   begin swap = frame_sync; busy = 1'b1; end
            default: busy = 1'b1;
        endcase
    end

    // A fresh step in the same clk as the pending flag is consumed keeps it set.
    always_comb begin
        step           = frame_sync & en & (frame_cnt_q == FC_LAST);
        frame_cnt_d    = frame_cnt_q;
        if (frame_sync && en) frame_cnt_d = step ? '0 : frame_cnt_q + 1'b1;
        scroll_pos_d   = scroll_pos_q + {{(POS_W-1){1'b0}}, step};
        step_pending_d = step | (step_pending_q & ~fill_start);
        fill_idx_d     = fill_we ? fill_idx_q + 4'd1 : 4'd0;
        pos_lat_d      = fill_start ? scroll_pos_q : pos_lat_q;
        bank_sel_d     = bank_sel_q ^ swap;
        rom_addr       = (pos_lat_q + {{(POS_W-4){1'b0}}, fill_idx_q}) & POS_MASK;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_idx_q     <= '0;
            pos_lat_q      <= '0;
            scroll_pos_q   <= '0;
            frame_cnt_q    <= '0;
            step_pending_q <= 1'b0;
            bank_sel_q     <= 1'b0;
        end else begin
            fill_idx_q     <= fill_idx_d;
            pos_lat_q      <= pos_lat_d;
            scroll_pos_q   <= scroll_pos_d;
            frame_cnt_q    <= frame_cnt_d;
            step_pending_q <= step_pending_d;
            bank_sel_q     <= bank_sel_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < MATRIX_DIM; c++)
                    bank_q[b][c] <= '0;
            row_data_q <= '0;
        end else begin
            if (fill_we) bank_q[~bank_sel_q][fill_idx_q] <= rom_data;
            row_data_q <= bank_q[bank_sel_q][col_addr];
        end
    end

    assign row_data   = row_data_q;
    assign scroll_pos = scroll_pos_q;

endmodule

// File: tb/tb_glyph_scroll_buffer.sv
// Bench for glyph_scroll_buffer: directed scroll/swap/enable/reset scenarios
// checked every cycle against a timing-level model of the visible frame.
module tb_glyph_scroll_buffer;

    localparam int SF    = 8;
    localparam int PW    = 6;
    localparam int STRIP = 64;

    logic          clk = 1'b0;
    logic          reset, en, frame_sync;
    logic [3:0]    col_addr;
    logic [15:0]   row_data;
    logic [PW-1:0] scroll_pos;
    logic          busy;

    always #5 clk = ~clk;

    glyph_scroll_buffer #(.NUM_GLYPHS(4), .STEP_FRAMES(SF), .POS_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .col_addr   (col_addr),
        .frame_sync (frame_sync),
        .row_data   (row_data),
        .scroll_pos (scroll_pos),
        .busy       (busy)
    );

    logic [15:0] strip [STRIP] = '{
        16'h1040, 16'h1040, 16'h1FC0, 16'h13FF, 16'h1040, 16'h0000, 16'h0FF0, 16'h1008,
        16'h1008, 16'h0FF0, 16'h0000, 16'h1FF8, 16'h0080, 16'h0080, 16'h1FF8, 16'h0000,
        16'h0200, 16'h0600, 16'h0E00, 16'h1E00, 16'h3E00, 16'h7E00, 16'hFE00, 16'hFFFE,
        16'hFE00, 16'h7E00, 16'h3E00, 16'h1E00, 16'h0E00, 16'h0600, 16'h0200, 16'h0000,
        16'h3FF0, 16'h2010, 16'h2010, 16'h2010, 16'h3FF0, 16'h0000, 16'h1FE0, 16'h2010,
        16'h2010, 16'h1FE0, 16'h0000, 16'h3C3C, 16'h4242, 16'h4242, 16'h3C3C, 16'h0000,
        16'h0000, 16'h7FE0, 16'h4020, 16'h4020, 16'h7FE0, 16'h0000, 16'h0810, 16'h1818,
        16'h3C3C, 16'h7E7E, 16'h3C3C, 16'h1818, 16'h0810, 16'h0000, 16'h0001, 16'h8001
    };

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the front image is a window offset (or blank); a fill started at
    // edge S becomes swappable at the first frame_sync on edge S+17 or later.
    int          m_cyc, m_fill_start, m_fill_off, m_front_off, m_fc, m_pos;
    bit          m_blank, m_have_fill, m_pend, m_step;
    logic [15:0] m_row;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cyc = 0; m_fill_start = 0; m_fill_off = 0; m_have_fill = 1'b1;
            m_blank = 1'b1; m_front_off = 0; m_fc = 0; m_pos = 0; m_pend = 1'b0;
            m_row = 16'h0000;
        end else begin
            m_cyc++;
            m_row  = m_blank ? 16'h0000 : strip[(m_front_off + int'(col_addr)) % STRIP];
            m_step = frame_sync && en && (m_fc == SF - 1);
            if (m_have_fill) begin
                if (frame_sync && m_cyc >= m_fill_start + 17) begin
                    m_blank = 1'b0; m_front_off = m_fill_off; m_have_fill = 1'b0;
                end
            end else if (m_pend) begin
                m_have_fill = 1'b1; m_fill_off = m_pos; m_fill_start = m_cyc; m_pend = 1'b0;
            end
            if (frame_sync && en) m_fc = m_step ? 0 : m_fc + 1;
            if (m_step) begin
                m_pos  = (m_pos + 1) % STRIP;
                m_pend = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cyc_row_data", row_data, m_row);
            check("cyc_scroll_pos", scroll_pos, m_pos);
            check("cyc_busy", busy, m_have_fill || m_pend);
        end
    end

    task automatic pulse_sync(input int gap);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic read_col(input logic [3:0] c, input logic [15:0] exp, input string name);
        col_addr = c;
        @(negedge clk);
        check(name, row_data, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset = 1'b0; en = 1'b1; frame_sync = 1'b0; col_addr = 4'd0;
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        check("rst_row_data", row_data, 16'h0000);
        check("rst_scroll_pos", scroll_pos, 0);
        check("rst_busy", busy, 1);
        #2 reset = 1'b1;

        // Initial fill completes, but nothing is shown until a frame boundary.
        repeat (20) @(negedge clk);
        check("ready_busy", busy, 1);
        for (int c = 0; c < 16; c++) read_col(c[3:0], 16'h0000, "blank_before_swap");

        pulse_sync(2);
        check("idle_busy", busy, 0);
        read_col(4'd0, 16'h1040, "g0_col0");
        read_col(4'd3, 16'h13FF, "g0_col3");

        repeat (7) pulse_sync(2);
        check("step_pos1", scroll_pos, 1);
        repeat (20) @(negedge clk);
        pulse_sync(2);
        read_col(4'd2, 16'h13FF, "off1_col2");

        for (int i = 0; i < 1000 && scroll_pos != 6'd63; i++) pulse_sync(1);
        check("reach_pos63", scroll_pos, 63);
        repeat (20) @(negedge clk);
        pulse_sync(2);
        repeat (20) @(negedge clk);
        pulse_sync(2);
        read_col(4'd0, 16'h8001, "wrap_col0_strip63");
        read_col(4'd1, 16'h1040, "wrap_col1_strip0");
        check("wrap_busy", busy, 0);

        // Frozen scroll: frame_cnt holds at 2 across 40 frames.
        read_col(4'd5, 16'h1040, "pre_freeze_col5");
        en = 1'b0;
        repeat (40) pulse_sync(1);
        check("freeze_pos", scroll_pos, 63);
        check("freeze_row", row_data, 16'h1040);
        check("freeze_busy", busy, 0);
        en = 1'b1;
        repeat (5) pulse_sync(1);
        check("resume_no_step", scroll_pos, 63);
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        check("resume_step_wrap", scroll_pos, 0);

        // Fill begins one clk later; abort it with fill_idx at 7.
        repeat (8) @(negedge clk);
        check("midfill_busy", busy, 1);
        #2 reset = 1'b0;
        #1 check("midfill_rst_row", row_data, 16'h0000);
        check("midfill_rst_pos", scroll_pos, 0);
        @(negedge clk);
        check("midfill_rst_row_clk", row_data, 16'h0000);
        #2 reset = 1'b1;
        repeat (20) @(negedge clk);
        check("refill_busy", busy, 1);
        read_col(4'd0, 16'h0000, "refill_blank");
        pulse_sync(2);
        read_col(4'd0, 16'h1040, "refill_col0");
        read_col(4'd3, 16'h13FF, "refill_col3");
        check("refill_pos", scroll_pos, 0);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/glyph_scroll_buffer.md
Name: glyph_scroll_buffer

Overview:
Upstream feeder for the 16x16 LED dot-matrix column scanner. It holds a double-buffered 16-column frame. The back bank is filled from an internal glyph ROM as a horizontally scrolled window over a strip of NUM_GLYPHS characters. The front bank is swapped in only at a scanner frame boundary, so the display never tears. The scanner presents its column address and receives that column's 16-bit row pattern.

Parameters:
NUM_GLYPHS, 4, number of 16x16 glyphs in the strip (power of two; strip length = NUM_GLYPHS*16 columns)
STEP_FRAMES, 8, scanner frames per one-column scroll step (>=1)
POS_W, 6, width of scroll position = log2(NUM_GLYPHS*16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
en  in  1  scroll enable; low freezes scroll position (display keeps refreshing)
col_addr  in  4  column currently driven by scanner
frame_sync  in  1  one-clk pulse when scanner column wraps 15->0
row_data  out  16  row pattern for col_addr (bit 15 = top row)
scroll_pos  out  POS_W  strip column shown at display column 0
busy  out  1  high while FSM is not IDLE (fill or swap pending)

Behaviour:
- Reset (async, reset=0): both banks cleared to 0; front-bank select=0; row_data=0; scroll_pos=0; frame_cnt=0; step_pending=0.
- FSM after reset release: FILL with fill_idx=0, so offset 0 loads without a request; busy=1.
- Read path: row_data <= front[col_addr] every clk; latency 1 clk; no handshake.
- frame_cnt: increments on frame_sync when en=1. When frame_cnt==STEP_FRAMES-1 with frame_sync and en: frame_cnt<=0, scroll_pos<=scroll_pos+1 (wraps 2^POS_W-1 -> 0), step_pending<=1.
- en=0: frame_cnt and scroll_pos hold; any fill/swap already in progress completes normally.
- FSM states:
  - IDLE: if step_pending, clear it and go to FILL with fill_idx=0.
  - FILL: each clk, back[fill_idx] <= rom[(scroll_pos_latched + fill_idx) mod strip]; fill_idx++. After fill_idx==15 is written, go to READY. scroll_pos_latched is captured on FILL entry. A scroll step during FILL only sets step_pending.
  - READY: on frame_sync, toggle bank select (back becomes front) and go to IDLE. No other exit.
- frame_sync during FILL or IDLE: no swap; front bank is redisplayed unchanged.
- Simultaneous frame_sync in READY and step boundary: swap occurs and step_pending sets in the same clk. IDLE then starts the new FILL on the next clk.
- Worst case fill-to-swap: 16 clk fill plus up to 1 frame wait. Steps arriving faster than that are coalesced: step_pending is a single flag, and scroll_pos still advances per step.
- The wrap of the glyph index across the strip end (col 63 -> 0) is seamless.
- busy = (state != IDLE) | step_pending.
- Reset mid-FILL/READY: all state is returned to reset values immediately, the front bank is blanked, and the fill restarts at offset 0.

Decomposition:
- Package glyph_pkg: MATRIX_DIM=16; FSM state enum {IDLE, FILL, READY}; the glyph ROM contents as 16-bit column constants, glyph-major.
  - GLYPH0 col0=16'h1040, col3=16'h13FF.
  - GLYPH1 col0=16'h0200, col7=16'hFFFE.
  - GLYPH2 col0=16'h3FF0.
  - GLYPH3 col1=16'h7FE0.
- Sub-module glyph_rom: combinational, addr POS_W bits -> 16-bit column word from package table.
- Top module holds FSM, counters, and both banks.

Test Plan:
- Reset then release, no frame_sync: busy=1 for 16 clk, then stays READY. row_data remains 0 for all col_addr.
- After initial fill, one frame_sync, then col_addr=0 -> row_data=16'h1040 one clk later. col_addr=3 -> 16'h13FF.
- en=1, STEP_FRAMES=8, drive 8 frame_syncs: scroll_pos=1 after the 8th. After fill and next frame_sync, col_addr=2 -> 16'h13FF (strip col 3).
- Force scroll_pos to 63 by stepping. After swap, col_addr=0 shows strip col 63 and col_addr=1 shows 16'h1040 (wrap).
- en=0 for 40 frame_syncs: scroll_pos and row_data unchanged. Set en=1: the step resumes from the held frame_cnt.
- Assert reset mid-FILL (fill_idx=7): row_data=0 immediately on the next clk. After release, the fill restarts at offset 0 and scroll_pos=0.
